nco_phase_detect: RTL and testbench

NCO_PHASE_DETECT -- requirements
Module: nco_phase_detect

---
 rtl/nco_phase_detect_if.sv | 34 +++
 rtl/nco_phase_detect.sv | 192 +++++++++++++++++++
 tb/tb_nco_phase_detect.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nco_phase_detect_if.sv
// ---------------------------------------------------------------------------
// nco_phase_detect_if
// Groups the sample handshake and the result bus of nco_phase_detect.
//   in_valid  : a sample is presented on sin_i/cos_i
//   in_ready  : the detector can take a sample this cycle
//   sin_i     : quadrature (Q) sample, signed, mpr bits
//   cos_i     : in-phase (I) sample, signed, mpr bits
//   phase_o   : atan2(sin_i, cos_i), unsigned, 2^apr == one full turn
//   freq_o    : phase_o minus the previous phase_o, modulo 2^apr
//   out_valid : a new result sits on phase_o/freq_o
// master = the sample source / result sink, slave = the detector.
// ---------------------------------------------------------------------------
interface nco_phase_detect_if #(
   parameter int mpr = 14,
   parameter int apr = 16
);
   logic                  in_valid;
   logic                  in_ready;
   logic signed [mpr-1:0] sin_i;
   logic signed [mpr-1:0] cos_i;
   logic [apr-1:0]        phase_o;
   logic [apr-1:0]        freq_o;
   logic                  out_valid;

   modport master (
      output in_valid, sin_i, cos_i,
      input  in_ready, phase_o, freq_o, out_valid
   );

   modport slave (
      input  in_valid, sin_i, cos_i,
      output in_ready, phase_o, freq_o, out_valid
   );
endinterface

// File: rtl/nco_phase_detect.sv
// ---------------------------------------------------------------------------
// nco_phase_detect
// Recovers the phase of an NCO sin/cos pair with an iterative vectoring
// CORDIC, and the per-sample phase step (the NCO phi_inc) as the difference
// between successive phases.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; wins over clken
//   clken : global enable, every register holds while low
//   bus   : nco_phase_detect_if.slave (sample handshake + results)
// Parameters: mpr = sample width, apr = phase width, niter = CORDIC steps.
// One sample at a time: accept, PRE, niter ITER cycles, DONE, back to IDLE.
// ---------------------------------------------------------------------------
module nco_phase_detect #(
   parameter int mpr   = 14,
   parameter int apr   = 16,
   parameter int niter = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clken,
   nco_phase_detect_if.slave  bus
);

   // Two guard bits: room for negating the most negative sample and for
   // the ~1.65x CORDIC gain.
   localparam int W   = mpr + 2;
   localparam int CW  = $clog2(niter) + 1;
   localparam logic [CW-1:0] LAST_ITER = CW'(niter - 1);

   // The arctangent table is held at 32-bit phase scale and rounded down
   // to apr bits.
   localparam int          RSH = 32 - apr;
   localparam logic [32:0] RND = (33'd1 << RSH) >> 1;

   typedef enum logic [1:0] {IDLE, PRE, ITER, DONE} state_t;

   state_t               state, next_state;
   logic signed [W-1:0]  x, y;
   logic signed [W-1:0]  x_shift, y_shift, x_next, y_next;
   logic [apr-1:0]       z, z_next, atan_val, result;
   logic [apr-1:0]       prev_phase, phase_r, freq_r;
   logic [CW-1:0]        iter;
   logic                 zero_q;
   logic                 first_flag;

   // round(atan(2^-i) * 2^apr / (2*pi)) for step i
   function automatic logic [apr-1:0] atan_lut(input logic [CW-1:0] idx);
      logic [31:0] t;
      logic [32:0] r;
      case (int'(idx))
         0:       t = 32'h2000_0000;
         1:       t = 32'h12E4_051E;
         2:       t = 32'h09FB_385B;
         3:       t = 32'h0511_11D4;
         4:       t = 32'h028B_0D43;
         5:       t = 32'h0145_D7E1;
         6:       t = 32'h00A2_F61E;
         7:       t = 32'h0051_7C55;
         8:       t = 32'h0028_BE53;
         9:       t = 32'h0014_5F2F;
         10:      t = 32'h000A_2F98;
         11:      t = 32'h0005_17CC;
         12:      t = 32'h0002_8BE6;
         13:      t = 32'h0001_45F3;
         14:      t = 32'h0000_A2FA;
         15:      t = 32'h0000_517D;
         16:      t = 32'h0000_28BE;
         17:      t = 32'h0000_145F;
         18:      t = 32'h0000_0A30;
         19:      t = 32'h0000_0518;
         20:      t = 32'h0000_028C;
         21:      t = 32'h0000_0146;
         22:      t = 32'h0000_00A3;
         23:      t = 32'h0000_0051;
         24:      t = 32'h0000_0029;
         25:      t = 32'h0000_0014;
         26:      t = 32'h0000_000A;
         27:      t = 32'h0000_0005;
         28:      t = 32'h0000_0003;
         29:      t = 32'h0000_0001;
         30:      t = 32'h0000_0001;
         default: t = 32'h0000_0000;
      endcase
      r = ({1'b0, t} + RND) >> RSH;
      return r[apr-1:0];
   endfunction

   // State register; reset overrides clken, otherwise advance only when
   // enabled.
   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else if (clken)
         state <= next_state;
   end

   // Next-state logic. A sample is only taken in IDLE; in_valid seen in any
   // other state is simply ignored.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.in_valid) next_state = PRE;
         PRE:     next_state = ITER;
         ITER:    if (iter == LAST_ITER) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // One CORDIC vectoring step: rotate toward the positive x axis, steering
   // by the sign of y, and accumulate the rotated angle in z. A zero input
   // has no defined angle, so it is forced to phase 0.
   always_comb begin
      x_shift  = x >>> iter;
      y_shift  = y >>> iter;
      atan_val = atan_lut(iter);
      x_next   = x;
      y_next   = y;
      z_next   = z;
      if (!y[W-1]) begin
         x_next = x + y_shift;
         y_next = y - x_shift;
         z_next = z + atan_val;
      end else begin
         x_next = x - y_shift;
         y_next = y + x_shift;
         z_next = z - atan_val;
      end
      result = zero_q ? '0 : z_next;
   end

   // Datapath. The sample is captured sign-extended on accept; PRE folds
   // the left half-plane onto the right by negating the vector and starting
   // z at half a turn, so the CORDIC only has to cover +/-90 degrees. The
   // last ITER step publishes the phase and its difference to the previous
   // one; the first result after reset has no predecessor and reports 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         x          <= '0;
         y          <= '0;
         z          <= '0;
         iter       <= '0;
         zero_q     <= 1'b0;
         first_flag <= 1'b1;
         prev_phase <= '0;
         phase_r    <= '0;
         freq_r     <= '0;
      end else if (clken) begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  x    <= {{2{bus.cos_i[mpr-1]}}, bus.cos_i};
                  y    <= {{2{bus.sin_i[mpr-1]}}, bus.sin_i};
                  z    <= '0;
                  iter <= '0;
               end
            end
            PRE: begin
               if (x[W-1]) begin
                  x <= -x;
                  y <= -y;
                  z <= {1'b1, {(apr-1){1'b0}}};
               end else begin
                  z <= '0;
               end
               zero_q <= (x == '0) && (y == '0);
               iter   <= '0;
            end
            ITER: begin
               x    <= x_next;
               y    <= y_next;
               z    <= z_next;
               iter <= iter + 1'b1;
               if (iter == LAST_ITER) begin
                  phase_r    <= result;
                  freq_r     <= first_flag ? '0 : result - prev_phase;
                  prev_phase <= result;
                  first_flag <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.phase_o   = phase_r;
   assign bus.freq_o    = freq_r;

endmodule

// File: tb/tb_nco_phase_detect.sv
// ---------------------------------------------------------------------------
// tb_nco_phase_detect
// Self-checking bench for nco_phase_detect (mpr=14, apr=16, niter=16).
// Expected phases come from fixed vectors or from real-valued atan2; the
// expected frequency is the difference of consecutive expected phases.
// ---------------------------------------------------------------------------
module tb_nco_phase_detect;

   localparam int  MPR   = 14;
   localparam int  APR   = 16;
   localparam int  NITER = 16;
   localparam int  LAT   = NITER + 2;
   localparam real PI    = 3.14159265358979323846;

   logic clk = 1'b0;
   logic reset;
   logic clken;

   nco_phase_detect_if #(.mpr(MPR), .apr(APR)) bus();

   nco_phase_detect #(.mpr(MPR), .apr(APR), .niter(NITER)) dut (
      .clk   (clk),
      .reset (reset),
      .clken (clken),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int tests    = 0;
   int failures = 0;
   bit rand_en  = 1'b0;
   int model_prev  = 0;
   bit model_first = 1'b1;

   typedef struct {
      int    cos_v;
      int    sin_v;
      int    exp_phase;
      int    tol;
      string name;
   } vec_t;

   vec_t vecs[9];
   int   v1_phase[9];

   // Shortest distance between two phases on the 2^16 circle
   function automatic int circ_dist(input int a, input int b);
      int d;
      d = (a - b) & 32'hFFFF;
      if (d > 32768) d = 65536 - d;
      return d;
   endfunction

   function automatic int round_real(input real v);
      if (v >= 0.0) return $rtoi(v + 0.5);
      return -$rtoi(-v + 0.5);
   endfunction

   // Reference phase: atan2 scaled so a full turn is 2^16
   function automatic int ref_phase(input int c, input int s);
      real p;
      if (c == 0 && s == 0) return 0;
      p = $atan2(real'(s), real'(c)) / (2.0 * PI) * 65536.0;
      if (p < 0.0) p = p + 65536.0;
      return round_real(p) % 65536;
   endfunction

   task automatic check_near(input string name, input int act, input int exp, input int tol);
      tests++;
      if (circ_dist(act, exp) > tol) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (tol %0d)", name, act, exp, tol);
      end
   endtask

   task automatic check_output(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One clock edge; reports whether it was an enabled edge, then picks the
   // clken value for the following edge.
   task automatic step(output bit en);
      @(posedge clk);
      en = clken;
      #1;
      clken = rand_en ? 1'($urandom_range(1)) : 1'b1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clken = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      clken = 1'b1;
      model_first = 1'b1;
      model_prev  = 0;
   endtask

   // Push one sample through: wait for in_ready, hold in_valid until an
   // enabled edge takes it, then count enabled edges (accept edge = 1)
   // until out_valid. Afterwards the result must hold over disabled edges.
   task automatic apply_stimulus(input int c, input int s,
                                 output logic [15:0] ph, output logic [15:0] fr,
                                 output int lat, output bit ok);
      bit en;
      int guard;
      ok  = 1'b0;
      lat = 0;
      ph  = '0;
      fr  = '0;
      guard = 0;
      while (!bus.in_ready && guard < 100) begin
         step(en);
         guard++;
      end
      bus.cos_i    = 14'(c);
      bus.sin_i    = 14'(s);
      bus.in_valid = 1'b1;
      guard = 0;
      do begin
         step(en);
         guard++;
      end while (!en && guard < 100);
      bus.in_valid = 1'b0;
      lat   = 1;
      guard = 0;
      while (!bus.out_valid && guard < 200) begin
         step(en);
         if (en) lat++;
         guard++;
      end
      if (bus.out_valid) begin
         ok = 1'b1;
         ph = bus.phase_o;
         fr = bus.freq_o;
         guard = 0;
         while (guard < 50) begin
            step(en);
            guard++;
            if (en) break;
            check_output("hold_valid", int'(bus.out_valid), 1);
            check_output("hold_phase", int'(bus.phase_o), int'(ph));
         end
      end
   endtask

   // Compare one result with the model and advance the model's history
   task automatic check_result(input string name, input int exp_ph, input int tol,
                               input logic [15:0] ph, input logic [15:0] fr,
                               input int lat, input bit ok);
      int exp_fr;
      check_output({name, "_done"}, int'(ok), 1);
      if (ok) begin
         check_near({name, "_phase"}, int'(ph), exp_ph, tol);
         exp_fr = model_first ? 0 : ((exp_ph - model_prev) & 32'hFFFF);
         check_near({name, "_freq"}, int'(fr), exp_fr, model_first ? 0 : 8);
         check_output({name, "_latency"}, lat, LAT);
      end
      model_prev  = exp_ph;
      model_first = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run", tests);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [15:0] ph, fr;
      int          lat;
      bit          ok;
      bit          en;
      int          c, s, phi;
      int          acc_edges[$];
      int          res_cnt;
      bit          rdy;

      vecs[0] = '{4096,     0, 16'h0000, 4, "v1_east"};
      vecs[1] = '{0,     4096, 16'h4000, 4, "v1_north"};
      vecs[2] = '{-4096,    0, 16'h8000, 4, "v1_west"};
      vecs[3] = '{0,    -4096, 16'hC000, 4, "v1_south"};
      vecs[4] = '{4096,  4096, 16'h2000, 4, "diag_ne"};
      vecs[5] = '{-4096, 4096, 16'h6000, 4, "diag_nw"};
      vecs[6] = '{4096, -4096, 16'hE000, 4, "diag_se"};
      vecs[7] = '{-8192, -8192, 16'hA000, 4, "v5_min"};
      vecs[8] = '{0,        0, 16'h0000, 0, "v5_zero"};

      reset        = 1'b1;
      clken        = 1'b1;
      bus.in_valid = 1'b0;
      bus.sin_i    = '0;
      bus.cos_i    = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      check_output("rst_in_ready",  int'(bus.in_ready), 1);
      check_output("rst_out_valid", int'(bus.out_valid), 0);
      check_output("rst_phase",     int'(bus.phase_o), 0);
      check_output("rst_freq",      int'(bus.freq_o), 0);

      // Axes, diagonals and extremes at full enable
      for (int i = 0; i < 9; i++) begin
         apply_stimulus(vecs[i].cos_v, vecs[i].sin_v, ph, fr, lat, ok);
         check_result(vecs[i].name, vecs[i].exp_phase, vecs[i].tol, ph, fr, lat, ok);
         v1_phase[i] = int'(ph);
      end

      // Same vectors with clken toggling at random: identical phases
      rand_en = 1'b1;
      for (int i = 0; i < 9; i++) begin
         apply_stimulus(vecs[i].cos_v, vecs[i].sin_v, ph, fr, lat, ok);
         check_result({"v4_", vecs[i].name}, vecs[i].exp_phase, vecs[i].tol, ph, fr, lat, ok);
         check_output("v4_same_as_v1", int'(ph), v1_phase[i]);
      end
      rand_en = 1'b0;
      clken   = 1'b1;

      // NCO tone with phi_inc = 0x0800
      do_reset();
      for (int k = 0; k < 8; k++) begin
         phi = (k * 16'h0800) & 32'hFFFF;
         c = round_real(8191.0 * $cos(2.0 * PI * real'(phi) / 65536.0));
         s = round_real(8191.0 * $sin(2.0 * PI * real'(phi) / 65536.0));
         apply_stimulus(c, s, ph, fr, lat, ok);
         check_result("v2_tone", ref_phase(c, s), 4, ph, fr, lat, ok);
         if (k == 0) check_output("v2_first_freq", int'(fr), 0);
         else        check_near("v2_freq", int'(fr), 16'h0800, 8);
      end

      // Wrap through zero: 0xFFF0 -> 0x0010
      for (int k = 0; k < 2; k++) begin
         phi = (k == 0) ? 16'hFFF0 : 16'h0010;
         c = round_real(8191.0 * $cos(2.0 * PI * real'(phi) / 65536.0));
         s = round_real(8191.0 * $sin(2.0 * PI * real'(phi) / 65536.0));
         apply_stimulus(c, s, ph, fr, lat, ok);
         check_result("v5_wrap", ref_phase(c, s), 4, ph, fr, lat, ok);
      end
      check_near("v5_wrap_freq", int'(fr), 16'h0020, 8);

      // Random samples of large magnitude against atan2
      for (int n = 0; n < 20; n++) begin
         do begin
            c = int'($urandom_range(16383)) - 8192;
            s = int'($urandom_range(16383)) - 8192;
         end while (c * c + s * s < 6144 * 6144);
         apply_stimulus(c, s, ph, fr, lat, ok);
         check_result("rand", ref_phase(c, s), 4, ph, fr, lat, ok);
      end

      // in_valid held high: one accept every NITER+3 cycles, one result each
      do_reset();
      bus.cos_i    = 14'(4096);
      bus.sin_i    = 14'(0);
      bus.in_valid = 1'b1;
      res_cnt      = 0;
      for (int e = 0; e < 4 * (NITER + 3); e++) begin
         rdy = bus.in_ready;
         step(en);
         if (rdy) acc_edges.push_back(e);
         if (bus.out_valid) res_cnt++;
      end
      bus.in_valid = 1'b0;
      for (int e = 0; e < 25; e++) begin
         step(en);
         if (bus.out_valid) res_cnt++;
      end
      check_output("v3_accepts", acc_edges.size(), 4);
      check_output("v3_results", res_cnt, 4);
      for (int i = 1; i < acc_edges.size(); i++)
         check_output("v3_spacing", acc_edges[i] - acc_edges[i-1], NITER + 3);

      // Reset in the middle of ITER step 5
      do_reset();
      apply_stimulus(0, 4096, ph, fr, lat, ok);
      check_result("v6_pre", 16'h4000, 4, ph, fr, lat, ok);
      bus.cos_i    = 14'(-4096);
      bus.sin_i    = 14'(2000);
      bus.in_valid = 1'b1;
      step(en);
      bus.in_valid = 1'b0;
      repeat (6) step(en);
      reset = 1'b1;
      clken = 1'b0;
      @(posedge clk); #1;
      check_output("v6_in_ready",  int'(bus.in_ready), 1);
      check_output("v6_out_valid", int'(bus.out_valid), 0);
      reset = 1'b0;
      clken = 1'b1;
      model_first = 1'b1;
      model_prev  = 0;
      res_cnt = 0;
      for (int e = 0; e < 25; e++) begin
         step(en);
         if (bus.out_valid) res_cnt++;
      end
      check_output("v6_no_result", res_cnt, 0);
      apply_stimulus(0, -4096, ph, fr, lat, ok);
      check_result("v6_post", 16'hC000, 4, ph, fr, lat, ok);
      check_output("v6_first_freq", int'(fr), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
